cia_timer_a: RTL and testbench
==============================

Name: cia_timer_a

Overview:
- CIA 8520 Timer A for the Minimig CIA blocks.
- 16-bit down counter with a 16-bit reload latch and a control register (CRA).
- Produces a one-cycle underflow pulse `ta` that feeds the interrupt-control block's TA input, and a `spmode` level that goes to the serial-port stage.
- Register access is through the CIA register-select decode and the shared bus-OR data path.

Parameters:
- LATCH_RST, 16'hFFFF, reset value of the reload latch and of the counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk7_en  in  1  clock enable; all state updates only on clk7_en cycles
- wr  in  1  bus write strobe (1 = write, 0 = read)
- tlo  in  1  select timer low byte (reg 4)
- thi  in  1  select timer high byte (reg 5)
- tcr  in  1  select control register CRA (reg 14)
- eclk  in  1  E-clock count enable, one clk7_en cycle wide
- data_in  in  8  bus write data
- data_out  out  8  read data; 8'h00 when no select is active or wr=1
- ta  out  1  underflow pulse to the interrupt stage, one clk7_en cycle
- spmode  out  1  CRA bit 6, to the serial-port stage

Behaviour:
- Reset (async, active-high) sets:
  - latch = LATCH_RST, counter = LATCH_RST
  - CRA = 7'h00
  - ta = 0
  - spmode = 0
- CRA bits:
  - 0 START (1 = run)
  - 1 PBON (stored only)
  - 2 OUTMODE (stored only)
  - 3 RUNMODE (1 = one-shot, 0 = continuous)
  - 4 LOAD (write-only strobe, always reads 0)
  - 5 INMODE (stored only; only eclk counting is implemented)
  - 6 SPMODE
  - 7 unused, reads 0
- Reads (combinational):
  - tlo → counter[7:0]
  - thi → counter[15:8]
  - tcr → {1'b0, CRA[6:5], 1'b0, CRA[3:0]}
- Write tlo: latch[7:0] <= data_in. The counter is not affected.
- Write thi: latch[15:8] <= data_in. Then:
  - If START=0: counter <= {data_in, latch[7:0]}.
  - If additionally RUNMODE=1 (or data written this cycle sets it): START <= 1 (one-shot auto-start).
  - If START=1: only the latch is updated.
- Write tcr:
  - CRA[6:5,3:0] <= data_in.
  - If data_in[4]=1: force load, counter <= latch (latch value before any same-cycle latch write).
- Count tick = clk7_en & eclk & START. On a tick:
  - If counter == 0: underflow.
  - Otherwise: counter <= counter − 1.
- Underflow:
  - counter <= latch.
  - ta = 1 for exactly the next clk7_en cycle.
  - If RUNMODE=1: START <= 0.
  - Period in continuous mode = latch + 1 ticks; latch=0 gives an underflow every tick.
- ta is registered: asserted in the cycle after the underflow tick, cleared on the next clk7_en cycle.
- Priority within one clk7_en cycle: force load or thi-load > tick. A load suppresses both the decrement and the underflow that cycle.
- Write of START=0 coinciding with a tick: the tick uses the old START (count happens), and the new START applies from the next cycle.
- Reset asserted mid-count: immediate return to reset values; a pending ta is cleared.
- Without clk7_en: no state change; data_out still reflects current state.

Decomposition:
- Shared package `cia_pkg` holds:
  - CRA bit-index constants: CRA_START=0, CRA_PBON=1, CRA_OUTMODE=2, CRA_RUNMODE=3, CRA_LOAD=4, CRA_INMODE=5, CRA_SPMODE=6
  - Register offsets for tlo/thi/tcr.
  - Timer B reuses all of these.
- One natural sub-module, `cia_downcnt16`:
  - 16-bit loadable down counter.
  - Inputs: load, load_val, tick.
  - Outputs: count, zero.
  - Shared later with timer B.

Test Plan:
1. Reset → data_out(tlo) = 8'hFF, data_out(thi) = 8'hFF, data_out(tcr) = 8'h00, ta = 0.
2. Write tlo = 8'h03, thi = 8'h00, then CRA = 8'h01 (continuous), eclk every clk7_en → ta pulses every 4 ticks; counter reads sequence 3, 2, 1, 0, 3; START stays 1.
3. CRA = 8'h08 (one-shot, stopped), write tlo = 8'h02, thi = 8'h00 → auto-start; exactly one ta pulse after 3 ticks; then CRA reads 8'h08 and counter holds 16'h0002.
4. While running at counter = 16'h0010, write CRA = 8'h11 (force load) with latch = 16'h0100 in the same cycle as a tick → counter = 16'h0100; no decrement, no ta.
5. While running, write thi = 8'h55 → counter unchanged; latch high = 8'h55, taking effect at the next underflow.
6. Assert reset during a ta pulse → ta drops immediately; all registers return to reset values regardless of clk7_en.

Source files
------------

// File: rtl/cia_pkg.sv
// -----------------------------------------------------------------------------
// cia_pkg
// Shared definitions for the Minimig CIA timer blocks (timer A and timer B).
//   - CRA/CRB bit positions
//   - Register offsets of the timer low/high bytes and control register
//   - Control register read-back helper
// -----------------------------------------------------------------------------
package cia_pkg;

    // Control register bit positions (same layout for CRA and CRB).
    localparam int CRA_START   = 0;
    localparam int CRA_PBON    = 1;
    localparam int CRA_OUTMODE = 2;
    localparam int CRA_RUNMODE = 3;
    localparam int CRA_LOAD    = 4;
    localparam int CRA_INMODE  = 5;
    localparam int CRA_SPMODE  = 6;

    // Register offsets decoded by the CIA register-select logic.
    localparam logic [3:0] REG_TLO = 4'h4;
    localparam logic [3:0] REG_THI = 4'h5;
    localparam logic [3:0] REG_TCR = 4'hE;

    // LOAD is a strobe and bit 7 does not exist, so both read back as 0.
    function automatic logic [7:0] cr_readback(input logic [6:0] cr);
        return {1'b0, cr[CRA_SPMODE], cr[CRA_INMODE], 1'b0,
                cr[CRA_RUNMODE], cr[CRA_OUTMODE], cr[CRA_PBON], cr[CRA_START]};
    endfunction

endpackage

// File: rtl/cia_timer_a_if.sv
// -----------------------------------------------------------------------------
// cia_timer_a_if
// Register bus seen by a CIA timer: write strobe, decoded selects and the
// 8-bit write/read data paths.
//   wr       bus write strobe (1 = write, 0 = read)
//   tlo/thi  timer low/high byte select
//   tcr      control register select
//   data_in  write data
//   data_out read data (0 when not selected, so it can be OR-ed onto the bus)
// -----------------------------------------------------------------------------
interface cia_timer_a_if;
    logic       wr;
    logic       tlo;
    logic       thi;
    logic       tcr;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output wr, tlo, thi, tcr, data_in,
        input  data_out
    );

    modport slave (
        input  wr, tlo, thi, tcr, data_in,
        output data_out
    );
endinterface

// File: rtl/cia_downcnt16.sv
// -----------------------------------------------------------------------------
// cia_downcnt16
// 16-bit loadable down counter shared by the CIA timers.
//   clk, reset  clock / asynchronous active-high reset (count <= RST_VAL)
//   en          clock enable; nothing changes when low
//   load        load load_val (has priority over tick)
//   load_val    value to load
//   tick        decrement by one
//   count       current count
//   zero        count == 0
// -----------------------------------------------------------------------------
module cia_downcnt16 #(
    parameter logic [15:0] RST_VAL = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        tick,
    output logic [15:0] count,
    output logic        zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= RST_VAL;
        end else if (en) begin
            if (load)
                count <= load_val;
            else if (tick)
                count <= count - 16'd1;
        end
    end

    assign zero = (count == 16'd0);

endmodule

// File: rtl/cia_timer_a.sv
// -----------------------------------------------------------------------------
// cia_timer_a
// CIA 8520 Timer A: 16-bit down counter, 16-bit reload latch and CRA.
//   clk      system clock
//   reset    asynchronous active-high reset
//   clk7_en  clock enable; all state updates only on enabled cycles
//   eclk     E-clock count enable (one clk7_en cycle wide)
//   bus      register bus (wr, tlo, thi, tcr, data_in, data_out)
//   ta       underflow pulse, one clk7_en cycle, to the interrupt block
//   spmode   CRA bit 6, to the serial-port stage
// -----------------------------------------------------------------------------
module cia_timer_a
    import cia_pkg::*;
#(
    parameter logic [15:0] LATCH_RST = 16'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk7_en,
    input  logic          eclk,
    cia_timer_a_if.slave  bus,
    output logic          ta,
    output logic          spmode
);

    logic [15:0] latch;
    logic [6:0]  cra;       // bit 4 (LOAD) is a strobe and is never stored
    logic [15:0] count;
    logic        zero;

    logic        wr_tlo, wr_thi, wr_tcr;
    logic        force_load, thi_load, tick, underflow;
    logic        runmode_next;
    logic        cnt_load;
    logic [15:0] cnt_val;

    assign wr_tlo = bus.wr & bus.tlo;
    assign wr_thi = bus.wr & bus.thi;
    assign wr_tcr = bus.wr & bus.tcr;

    assign force_load = wr_tcr & bus.data_in[CRA_LOAD];
    // Writing the high byte of a stopped timer also transfers it to the counter.
    assign thi_load   = wr_thi & ~cra[CRA_START];
    // Ticks use the START value held before any same-cycle CRA write.
    assign tick       = eclk & cra[CRA_START];
    // Any load this cycle wins over the tick, so no underflow is seen either.
    assign underflow  = tick & zero & ~force_load & ~thi_load;

    // One-shot auto-start also honours a RUNMODE being written this cycle.
    assign runmode_next = cra[CRA_RUNMODE] | (wr_tcr & bus.data_in[CRA_RUNMODE]);

    // Force load and underflow reload both use the latch value held before
    // any same-cycle latch write.
    always_comb begin
        cnt_load = force_load | thi_load | underflow;
        cnt_val  = latch;
        if (!force_load && thi_load)
            cnt_val = {bus.data_in, latch[7:0]};
    end

    cia_downcnt16 #(
        .RST_VAL (LATCH_RST)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .en       (clk7_en),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tick     (tick),
        .count    (count),
        .zero     (zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch <= LATCH_RST;
            cra   <= 7'h00;
            ta    <= 1'b0;
        end else if (clk7_en) begin
            if (wr_tlo)
                latch[7:0] <= bus.data_in;
            if (wr_thi)
                latch[15:8] <= bus.data_in;
            if (wr_tcr)
                cra <= {bus.data_in[6:5], 1'b0, bus.data_in[3:0]};
            if (thi_load && runmode_next)
                cra[CRA_START] <= 1'b1;
            // One-shot stop on underflow overrides a same-cycle START write.
            if (underflow && cra[CRA_RUNMODE])
                cra[CRA_START] <= 1'b0;
            ta <= underflow;
        end
    end

    assign spmode = cra[CRA_SPMODE];

    always_comb begin
        bus.data_out = 8'h00;
        if (!bus.wr) begin
            if (bus.tlo)
                bus.data_out = count[7:0];
            else if (bus.thi)
                bus.data_out = count[15:8];
            else if (bus.tcr)
                bus.data_out = cr_readback(cra);
        end
    end

endmodule

// File: tb/tb_cia_timer_a.sv
// -----------------------------------------------------------------------------
// tb_cia_timer_a
// Self-checking bench for cia_timer_a: directed scenarios followed by random
// register traffic, compared against a behavioural model of the timer.
// -----------------------------------------------------------------------------
module tb_cia_timer_a;
    import cia_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic clk7_en;
    logic eclk;
    logic ta;
    logic spmode;

    cia_timer_a_if bus ();

    cia_timer_a #(
        .LATCH_RST (16'hFFFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clk7_en (clk7_en),
        .eclk    (eclk),
        .bus     (bus.slave),
        .ta      (ta),
        .spmode  (spmode)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state.
    int m_latch, m_count;
    bit m_start, m_pbon, m_outmode, m_runmode, m_inmode, m_spmode, m_ta;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_latch = 16'hFFFF; m_count = 16'hFFFF;
        m_start = 0; m_pbon = 0; m_outmode = 0; m_runmode = 0;
        m_inmode = 0; m_spmode = 0; m_ta = 0;
    endtask

    function automatic int m_cra_read();
        return (int'(m_spmode) << 6) | (int'(m_inmode) << 5) | (int'(m_runmode) << 3) |
               (int'(m_outmode) << 2) | (int'(m_pbon) << 1) | int'(m_start);
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_clock();
        int n_latch, n_count;
        bit n_start, n_ta, loaded, old_run, old_start;
        logic [7:0] d;
        if (reset || !clk7_en) return;
        d = bus.data_in;
        n_latch = m_latch; n_count = m_count; n_start = m_start;
        n_ta = 0; loaded = 0;
        old_run = m_runmode; old_start = m_start;
        if (bus.wr && bus.tcr) begin
            m_pbon = d[1]; m_outmode = d[2]; m_runmode = d[3];
            m_inmode = d[5]; m_spmode = d[6]; n_start = d[0];
        end
        if (bus.wr && bus.tlo)
            n_latch = (n_latch & 16'hFF00) | int'(d);
        if (bus.wr && bus.thi) begin
            n_latch = (n_latch & 16'h00FF) | (int'(d) << 8);
            if (!old_start) begin
                n_count = (int'(d) << 8) + (m_latch % 256);
                loaded = 1;
                if (old_run || m_runmode) n_start = 1;
            end
        end
        if (bus.wr && bus.tcr && d[4]) begin
            n_count = m_latch;
            loaded = 1;
        end
        if (old_start && eclk && !loaded) begin
            if (m_count == 0) begin
                n_count = m_latch;
                n_ta = 1;
                if (old_run) n_start = 0;
            end else begin
                n_count = m_count - 1;
            end
        end
        m_latch = n_latch; m_count = n_count; m_start = n_start; m_ta = n_ta;
    endtask

    task automatic idle();
        bus.wr = 0; bus.tlo = 0; bus.thi = 0; bus.tcr = 0; bus.data_in = 8'h00;
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        chk("ta", {15'd0, ta}, {15'd0, m_ta});
        chk("spmode", {15'd0, spmode}, {15'd0, m_spmode});
    endtask

    // Combinational reads between clock edges.
    task automatic check_reads();
        idle();
        bus.tlo = 1; #1;
        chk("rd_tlo", {8'd0, bus.data_out}, 16'(m_count % 256));
        bus.tlo = 0; bus.thi = 1; #1;
        chk("rd_thi", {8'd0, bus.data_out}, 16'(m_count / 256));
        bus.thi = 0; bus.tcr = 1; #1;
        chk("rd_tcr", {8'd0, bus.data_out}, 16'(m_cra_read()));
        bus.tcr = 0; bus.wr = 1; bus.tlo = 1; #1;
        chk("rd_wr_hi", {8'd0, bus.data_out}, 16'h0000);
        idle();
    endtask

    // sel: 0 = tlo, 1 = thi, 2 = tcr
    task automatic wr_reg(input int sel, input logic [7:0] d, input logic e);
        idle();
        eclk = e;
        bus.wr = 1; bus.data_in = d;
        bus.tlo = (sel == 0); bus.thi = (sel == 1); bus.tcr = (sel == 2);
        step();
        idle();
    endtask

    initial begin
        logic [3:0] addr;
        int op;
        idle();
        reset = 1; clk7_en = 0; eclk = 0;
        model_reset();

        // 1. Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reads();
        chk("rst_ta", {15'd0, ta}, 16'h0000);
        bus.tlo = 1; #1; chk("rst_tlo_ff", {8'd0, bus.data_out}, 16'h00FF);
        idle(); bus.tcr = 1; #1; chk("rst_tcr_00", {8'd0, bus.data_out}, 16'h0000);
        idle();
        @(posedge clk); #1;
        reset = 0; clk7_en = 1;

        // 2. Continuous mode, latch = 3
        wr_reg(0, 8'h03, 0);
        wr_reg(1, 8'h00, 0);
        check_reads();
        chk("cont_load", {8'd0, bus.data_out}, 16'h0000);
        wr_reg(2, 8'h01, 0);
        eclk = 1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("cont_ta", {15'd0, ta}, (k % 4 == 0) ? 16'h0001 : 16'h0000);
            check_reads();
            bus.tlo = 1; #1;
            chk("cont_cnt", {8'd0, bus.data_out}, 16'(3 - (k % 4)));
            idle();
        end

        // 3. One-shot auto-start
        wr_reg(2, 8'h08, 0);
        wr_reg(0, 8'h02, 0);
        wr_reg(1, 8'h00, 0);
        check_reads();
        eclk = 1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("os_ta", {15'd0, ta}, (k == 3) ? 16'h0001 : 16'h0000);
            check_reads();
        end
        bus.tcr = 1; #1; chk("os_cra", {8'd0, bus.data_out}, 16'h0008);
        idle(); bus.tlo = 1; #1; chk("os_cnt", {8'd0, bus.data_out}, 16'h0002);
        idle();

        // 4. Force load coinciding with a tick
        wr_reg(2, 8'h00, 0);
        wr_reg(0, 8'h10, 0);
        wr_reg(1, 8'h00, 0);
        wr_reg(2, 8'h01, 0);
        wr_reg(0, 8'h00, 0);
        wr_reg(1, 8'h01, 0);
        check_reads();
        wr_reg(2, 8'h11, 1);
        chk("fl_ta", {15'd0, ta}, 16'h0000);
        bus.thi = 1; #1; chk("fl_cnt_hi", {8'd0, bus.data_out}, 16'h0001);
        idle(); bus.tlo = 1; #1; chk("fl_cnt_lo", {8'd0, bus.data_out}, 16'h0000);
        idle();

        // 5. High-byte write while running only touches the latch
        wr_reg(1, 8'h55, 0);
        check_reads();
        bus.thi = 1; #1; chk("run_thi_cnt", {8'd0, bus.data_out}, 16'h0001);
        idle();
        eclk = 1;
        for (int k = 1; k <= 257; k++) step();
        chk("run_uf_ta", {15'd0, ta}, 16'h0001);
        check_reads();
        bus.thi = 1; #1; chk("run_uf_hi", {8'd0, bus.data_out}, 16'h0055);
        idle();

        // 6. Reset during the ta pulse, without clk7_en
        clk7_en = 0; eclk = 0;
        reset = 1; #1;
        model_reset();
        chk("rst_mid_ta", {15'd0, ta}, 16'h0000);
        check_reads();
        @(posedge clk); #1;
        reset = 0; clk7_en = 1;

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            clk7_en = ($urandom % 4) != 0;
            eclk = ($urandom % 3) != 0;
            op = int'($urandom % 10);
            addr = (op == 0) ? REG_TLO : (op == 1) ? REG_THI : (op == 2) ? REG_TCR : 4'h0;
            if (addr != 4'h0) begin
                bus.wr = 1;
                bus.tlo = (addr == REG_TLO);
                bus.thi = (addr == REG_THI);
                bus.tcr = (addr == REG_TCR);
                if (addr == REG_TLO) bus.data_in = 8'($urandom % 6);
                else if (addr == REG_THI) bus.data_in = (($urandom % 8) == 0) ? 8'($urandom) : 8'h00;
                else bus.data_in = 8'($urandom) & 8'h7F;
            end
            step();
            check_reads();
            if (c == 300) begin
                reset = 1; #1;
                model_reset();
                check_reads();
                chk("rnd_rst_ta", {15'd0, ta}, 16'h0000);
                @(posedge clk); #1;
                reset = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
